// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, defaults and state type for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_word_w = 16;
    localparam int c_addr_w = 16;

    typedef logic [c_word_w-1:0] word_t;
    typedef logic [c_addr_w-1:0] addr_t;

    localparam addr_t c_default_reset_pc  = 16'h0000;
    localparam word_t c_default_halt_word = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register: valid flag plus instruction, PC, PC+1.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_clear,
    input  word_t i_instr,
    input  addr_t i_pc,
    output logic  o_valid,
    output word_t o_instr,
    output addr_t o_pc,
    output addr_t o_pc_plus1
);

    logic  r_valid;
    word_t r_instr;
    addr_t r_pc;
    addr_t r_pc_plus1;

    // Clear only drops the valid flag; data keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_pc_plus1 <= '0;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc + 16'd1;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc_plus1;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC, fetch state machine and IF/ID capture for a 16-bit core.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC  = c_default_reset_pc,
    parameter word_t HALT_WORD = c_default_halt_word
) (
    input  logic  clk,
    input  logic  rst_n,
    output addr_t address,
    input  word_t instruction,
    input  logic  id_ready,
    input  logic  redirect,
    input  addr_t redirect_target,
    output logic  if_id_valid,
    output word_t if_id_instruction,
    output addr_t if_id_pc,
    output addr_t if_id_pc_plus1,
    output logic  halted
);

    fetch_state_t r_state;
    addr_t        r_pc;
    logic         r_halted;
    logic         w_fetch;
    logic         w_take_redirect;
    logic         w_clear;

    assign w_take_redirect = redirect && (r_state != ST_BOOT);
    assign w_fetch         = (r_state == ST_RUN) && (!if_id_valid || id_ready) && !redirect;
    assign w_clear         = w_take_redirect || (!w_fetch && if_id_valid && id_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (r_state == ST_BOOT) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else if (w_take_redirect) begin
            r_state  <= ST_RUN;
            r_pc     <= redirect_target;
            r_halted <= 1'b0;
        end else if (w_fetch) begin
            r_pc <= r_pc + 16'd1;
            // The halt word is still delivered; only further fetches stop.
            if (instruction == HALT_WORD) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end
        end
    end

    assign address = r_pc;
    assign halted  = r_halted;

    if_id_register u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_fetch),
        .i_clear    (w_clear),
        .i_instr    (instruction),
        .i_pc       (r_pc),
        .o_valid    (if_id_valid),
        .o_instr    (if_id_instruction),
        .o_pc       (if_id_pc),
        .o_pc_plus1 (if_id_pc_plus1)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Randomized self-checking bench with a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [15:0] c_halt = 16'hFFFF;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] instruction;
    logic        id_ready;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        if_id_valid;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        halted;

    logic [15:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_booting;
    bit          m_halted;
    bit          m_valid;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;

    instruction_fetch_unit #(
        .RESET_PC  (16'h0000),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .address           (address),
        .instruction       (instruction),
        .id_ready          (id_ready),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .if_id_valid       (if_id_valid),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .halted            (halted)
    );

    assign instruction = mem[address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_valid   = 1'b0;
        m_pc      = 16'h0000;
        m_instr   = 16'h0000;
        m_ipc     = 16'h0000;
    endtask

    task automatic compare_all();
        int plus1;
        plus1 = (int'(m_ipc) + 1) % 65536;
        check_eq("valid",   {15'd0, if_id_valid}, {15'd0, m_valid});
        check_eq("halted",  {15'd0, halted},      {15'd0, m_halted});
        check_eq("address", address,              m_pc);
        if (m_valid) begin
            check_eq("instr",  if_id_instruction, m_instr);
            check_eq("pc",     if_id_pc,          m_ipc);
            check_eq("pc_p1",  if_id_pc_plus1,    plus1[15:0]);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the stated rules, compare.
    task automatic cycle(input bit rdy, input bit redir, input logic [15:0] tgt);
        bit          can_fetch;
        logic [15:0] word;
        id_ready        = rdy;
        redirect        = redir;
        redirect_target = tgt;
        word      = mem[m_pc];
        can_fetch = !m_booting && !m_halted && (!m_valid || rdy) && !redir;
        @(posedge clk);
        #1;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (redir) begin
            m_pc     = tgt;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (can_fetch) begin
            m_instr = word;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            if (word == c_halt) m_halted = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"},  {15'd0, if_id_valid}, 16'd0);
        check_eq({tag, "_instr"},  if_id_instruction,    16'd0);
        check_eq({tag, "_pc"},     if_id_pc,             16'd0);
        check_eq({tag, "_pc_p1"},  if_id_pc_plus1,       16'd0);
        check_eq({tag, "_halted"}, {15'd0, halted},      16'd0);
        check_eq({tag, "_addr"},   address,              16'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = (($urandom % 16) == 0) ? c_halt : 16'($urandom);
        end
        mem[0]       = 16'h1111;
        mem[1]       = 16'h2222;
        mem[2]       = 16'h3333;
        mem[3]       = 16'h0303;
        mem[4]       = 16'h0404;
        mem[5]       = c_halt;
        mem[16'h40]  = 16'h4040;
        mem[16'hFFFF] = 16'h7FFF;

        rst_n           = 1'b0;
        id_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        model_reset();
        #1;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot cycle, then sequential fetch
        cycle(1, 1, 16'h1234);
        check_eq("boot_no_fetch", {15'd0, if_id_valid}, 16'd0);
        cycle(1, 0, 16'h0);
        check_eq("first_word", if_id_instruction, 16'h1111);
        cycle(1, 0, 16'h0);
        check_eq("second_word", if_id_instruction, 16'h2222);

        // Stall holds everything
        repeat (3) cycle(0, 0, 16'h0);
        check_eq("stall_addr", address, 16'h0002);
        check_eq("stall_word", if_id_instruction, 16'h2222);
        cycle(1, 0, 16'h0);
        check_eq("resume_pc", if_id_pc, 16'h0002);

        // Redirect beats stall
        cycle(0, 1, 16'h0040);
        check_eq("redir_flush", {15'd0, if_id_valid}, 16'd0);
        check_eq("redir_addr", address, 16'h0040);
        cycle(1, 0, 16'h0);
        check_eq("redir_word", if_id_instruction, 16'h4040);

        // Halt
        cycle(1, 1, 16'h0003);
        repeat (3) cycle(1, 0, 16'h0);
        check_eq("halt_word", if_id_instruction, 16'hFFFF);
        check_eq("halt_flag", {15'd0, halted}, 16'd1);
        check_eq("halt_addr", address, 16'h0006);
        cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        check_eq("halt_drain", {15'd0, if_id_valid}, 16'd0);
        check_eq("halt_addr_hold", address, 16'h0006);
        cycle(1, 1, 16'h0000);
        check_eq("halt_clear", {15'd0, halted}, 16'd0);

        // PC wrap
        cycle(1, 1, 16'hFFFF);
        cycle(1, 0, 16'h0);
        check_eq("wrap_pc", if_id_pc, 16'hFFFF);
        check_eq("wrap_pc_p1", if_id_pc_plus1, 16'h0000);
        check_eq("wrap_addr", address, 16'h0000);

        // Asynchronous reset with a valid entry held
        cycle(0, 0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          rdy;
            bit          redir;
            logic [15:0] tgt;
            rdy   = ($urandom % 10) < 7;
            redir = ($urandom % 12) == 0;
            tgt   = (($urandom % 4) == 0) ? 16'($urandom_range(65530, 65535)) : 16'($urandom);
            cycle(rdy, redir, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
